// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq: input state channel, output state channel and busy.
// master = producer/consumer side (bench or upstream stage), slave = the engine.
interface sub_bytes_seq_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_state;
  logic                  in_inv;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_state;
  logic                  busy;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes/InvSubBytes engine: LANES registered S-box lookups per cycle.
// Define SUBBYTES_INV_EN to build the inverse tables and honour in_inv; otherwise forward only.
module sub_bytes_seq #(
  parameter int NBYTES = 16,
  parameter int LANES  = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  sub_bytes_seq_if.slave bus
);
  localparam int G  = NBYTES / LANES;
  localparam int KW = $clog2(G + 1);

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    if (NBYTES % LANES != 0) begin : g_bad_cfg
      $error("sub_bytes_seq: NBYTES must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [8*NBYTES-1:0] data_q;
  logic [8*NBYTES-1:0] res_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                accept;
  logic [KW-1:0]       grp;
  logic [KW-1:0]       wgrp;
  logic [7:0]          addr  [LANES];
  logic [7:0]          fwd_q [LANES];
  logic [7:0]          sub   [LANES];

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = res_q;
  assign bus.busy      = busy_q;

  // The extra write-only cycle (k == G) re-reads group 0; its data is never written.
  assign grp  = (k_q < KW'(G)) ? k_q : '0;
  assign wgrp = k_q - KW'(1);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_addr
    assign addr[gi] = data_q[8*NBYTES-1 - 8*(int'(grp)*LANES + gi) -: 8];
  end

  always_ff @(posedge sys_clk) begin
    for (int l = 0; l < LANES; l++) begin
      fwd_q[l] <= SBOX_FWD[2047 - 8*int'(addr[l]) -: 8];
    end
  end

`ifdef SUBBYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic       mode_q;
  logic [7:0] inv_q [LANES];

  always_ff @(posedge sys_clk) begin
    for (int l = 0; l < LANES; l++) begin
      inv_q[l] <= SBOX_INV[2047 - 8*int'(addr[l]) -: 8];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= bus.in_inv;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_sel
    assign sub[gi] = mode_q ? inv_q[gi] : fwd_q[gi];
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_sel
    assign sub[gi] = fwd_q[gi];
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      data_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.in_state;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          // Lookup of group k-1 landed in the ROM registers last cycle; commit it now.
          if (k_q != '0) begin
            for (int l = 0; l < LANES; l++) begin
              res_q[8*NBYTES-1 - 8*(int'(wgrp)*LANES + l) -: 8] <= sub[l];
            end
          end
          if (k_q == KW'(G)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              data_q  <= bus.in_state;
              k_q     <= '0;
              state_q <= LOOKUP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule
